// File: rtl/alu_pkg.sv
// Shared constants for the execute-lane ALU: op-select bit indices and widths.
// Imported by the combinational core and the registered top level.
package alu_pkg;

    localparam int DATA_W     = 16;
    localparam int ALU_CTRL_W = 12;
    localparam int IMM_W      = 5;

    localparam int ALU_ADD = 0;
    localparam int ALU_LD  = 1;
    localparam int ALU_ST  = 2;
    localparam int ALU_SUB = 3;
    localparam int ALU_CMP = 4;
    localparam int ALU_MUL = 5;
    localparam int ALU_LSL = 6;
    localparam int ALU_OR  = 7;
    localparam int ALU_AND = 8;
    localparam int ALU_NOT = 9;
    localparam int ALU_MOV = 10;
    localparam int ALU_LSR = 11;

    function automatic logic [DATA_W-1:0] signExtImm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath. The lowest set bit of alusignals selects
// the operation; an all-zero select yields zero.
module alu_core
    import alu_pkg::*;
(
    input  logic [ALU_CTRL_W-1:0] alusignals,
    input  logic [DATA_W-1:0]     opA,
    input  logic [DATA_W-1:0]     opB,
    output logic [DATA_W-1:0]     result
);

    logic [2*DATA_W-1:0] product;
    logic                aGtB;
    logic                aEqB;

    assign product = opA * opB;
    assign aGtB    = $signed(opA) > $signed(opB);
    assign aEqB    = (opA == opB);

    // Ordered if/else chain gives the lowest-index-wins priority.
    always_comb begin
        result = '0;
        if (alusignals[ALU_ADD] || alusignals[ALU_LD] || alusignals[ALU_ST]) begin
            result = opA + opB;
        end else if (alusignals[ALU_SUB]) begin
            result = opA - opB;
        end else if (alusignals[ALU_CMP]) begin
            result = {{(DATA_W-2){1'b0}}, aGtB, aEqB};
        end else if (alusignals[ALU_MUL]) begin
            result = product[DATA_W-1:0];
        end else if (alusignals[ALU_LSL]) begin
            result = opA << opB[3:0];
        end else if (alusignals[ALU_OR]) begin
            result = opA | opB;
        end else if (alusignals[ALU_AND]) begin
            result = opA & opB;
        end else if (alusignals[ALU_NOT]) begin
            result = ~opB;
        end else if (alusignals[ALU_MOV]) begin
            result = opB;
        end else if (alusignals[ALU_LSR]) begin
            result = opA >> opB[3:0];
        end
    end

    logic unusedProduct;
    assign unusedProduct = ^product[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/alu.sv
// Registered 16-bit ALU for one execute lane: selects operand B, computes the
// result one clock later and forwards the instruction word, squashing on a taken branch.
module alu
    import alu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ALU_CTRL_W-1:0] alusignals,
    input  logic [DATA_W-1:0]     instrin,
    input  logic [DATA_W-1:0]     op1,
    input  logic [DATA_W-1:0]     op2,
    input  logic [IMM_W-1:0]      immx,
    input  logic                  isimmediate,
    input  logic                  is_branch_takenin,
    output logic [DATA_W-1:0]     aluresult,
    output logic [DATA_W-1:0]     instrout
);

    logic [DATA_W-1:0] opB;
    logic [DATA_W-1:0] coreResult;
    logic [DATA_W-1:0] result_d;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] instr_d;
    logic [DATA_W-1:0] instr_q;

    assign opB = isimmediate ? signExtImm(immx) : op2;

    alu_core u_core (
        .alusignals (alusignals),
        .opA        (op1),
        .opB        (opB),
        .result     (coreResult)
    );

    // A taken branch turns this lane's slot into a NOP for one cycle only.
    always_comb begin
        result_d = coreResult;
        instr_d  = instrin;
        if (is_branch_takenin) begin
            result_d = '0;
            instr_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            instr_q  <= '0;
        end else begin
            result_q <= result_d;
            instr_q  <= instr_d;
        end
    end

    assign aluresult = result_q;
    assign instrout  = instr_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed boundary cases followed by random
// operations compared against an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        reset;
    logic [11:0] alusignals;
    logic [15:0] instrin;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [4:0]  immx;
    logic        isimmediate;
    logic        is_branch_takenin;
    logic [15:0] aluresult;
    logic [15:0] instrout;

    int assertCount;
    int failCount;

    alu dut (
        .clk               (clk),
        .reset             (reset),
        .alusignals        (alusignals),
        .instrin           (instrin),
        .op1               (op1),
        .op2               (op2),
        .immx              (immx),
        .isimmediate       (isimmediate),
        .is_branch_takenin (is_branch_takenin),
        .aluresult         (aluresult),
        .instrout          (instrout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: pick the lowest set select bit, then evaluate with plain integer arithmetic.
    function automatic logic [15:0] refAlu(input logic [11:0] sel, input logic [15:0] a,
                                           input logic [15:0] b);
        int     idx;
        longint ua;
        longint ub;
        longint sa;
        longint sb;
        longint r;
        idx = -1;
        for (int i = 11; i >= 0; i--) if (sel[i]) idx = i;
        ua = a;
        ub = b;
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        case (idx)
            0, 1, 2: r = ua + ub;
            3:       r = ua - ub + 65536;
            4:       r = ((sa > sb) ? 2 : 0) + ((ua == ub) ? 1 : 0);
            5:       r = ua * ub;
            6:       r = ua * (longint'(1) << (ub % 16));
            7:       r = ua | ub;
            8:       r = ua & ub;
            9:       r = 65535 - ub;
            10:      r = ub;
            11:      r = ua / (longint'(1) << (ub % 16));
            default: r = 0;
        endcase
        r = r % 65536;
        return r[15:0];
    endfunction

    function automatic logic [15:0] effectiveB(input logic isImm, input logic [4:0] imm,
                                               input logic [15:0] reg2);
        int v;
        if (!isImm) return reg2;
        v = (imm >= 16) ? int'(imm) - 32 + 65536 : int'(imm);
        return v[15:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] expResult,
                               input logic [15:0] expInstr);
        assertCount++;
        assert (aluresult === expResult)
        else begin
            failCount++;
            $error("[TB] FAIL %s aluresult got %h expected %h", tag, aluresult, expResult);
        end
        assertCount++;
        assert (instrout === expInstr)
        else begin
            failCount++;
            $error("[TB] FAIL %s instrout got %h expected %h", tag, instrout, expInstr);
        end
    endtask

    // Drive one operation at the falling edge, clock it in and check the registered outputs.
    task automatic applyStimulus(input string tag, input logic [11:0] sel,
                                 input logic [15:0] instr, input logic [15:0] a,
                                 input logic [15:0] b, input logic [4:0] imm,
                                 input logic isImm, input logic squash);
        logic [15:0] expR;
        logic [15:0] expI;
        @(negedge clk);
        alusignals        = sel;
        instrin           = instr;
        op1               = a;
        op2               = b;
        immx              = imm;
        isimmediate       = isImm;
        is_branch_takenin = squash;
        expR = squash ? 16'h0000 : refAlu(sel, a, effectiveB(isImm, imm, b));
        expI = squash ? 16'h0000 : instr;
        @(posedge clk);
        #1;
        checkOutput(tag, expR, expI);
    endtask

    initial begin
        logic [11:0] sel;
        assertCount = 0;
        failCount   = 0;

        reset             = 1'b1;
        alusignals        = 12'h001;
        instrin           = 16'hABCD;
        op1               = 16'h0003;
        op2               = 16'h0004;
        immx              = 5'h00;
        isimmediate       = 1'b0;
        is_branch_takenin = 1'b0;
        #1;
        checkOutput("reset_initial", 16'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hold", 16'h0000, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus("add",        12'h001, 16'h1111, 16'h0003, 16'h0004, 5'h00, 1'b0, 1'b0);
        applyStimulus("sub",        12'h008, 16'h2222, 16'h0003, 16'h0004, 5'h00, 1'b0, 1'b0);
        applyStimulus("and",        12'h100, 16'h3333, 16'hF0F0, 16'h0FF0, 5'h00, 1'b0, 1'b0);
        applyStimulus("or",         12'h080, 16'h4444, 16'hF0F0, 16'h0FF0, 5'h00, 1'b0, 1'b0);
        applyStimulus("imm_pos",    12'h001, 16'h5555, 16'h0002, 16'h7777, 5'h01, 1'b1, 1'b0);
        applyStimulus("imm_neg",    12'h001, 16'h6666, 16'h0002, 16'h7777, 5'h1F, 1'b1, 1'b0);
        applyStimulus("squash",     12'h001, 16'h1234, 16'h0002, 16'h0000, 5'h01, 1'b1, 1'b1);
        applyStimulus("unsquash",   12'h001, 16'h1234, 16'h0002, 16'h0000, 5'h01, 1'b1, 1'b0);
        applyStimulus("priority",   12'h009, 16'h7777, 16'h0003, 16'h0004, 5'h00, 1'b0, 1'b0);
        applyStimulus("none",       12'h000, 16'h8888, 16'h0003, 16'h0004, 5'h00, 1'b0, 1'b0);
        applyStimulus("cmp_eq",     12'h010, 16'h9999, 16'h0005, 16'h0005, 5'h00, 1'b0, 1'b0);
        applyStimulus("cmp_signed", 12'h010, 16'h9998, 16'h0001, 16'hFFFF, 5'h00, 1'b0, 1'b0);
        applyStimulus("mul",        12'h020, 16'hAAAA, 16'h1234, 16'h0100, 5'h00, 1'b0, 1'b0);
        applyStimulus("lsl",        12'h040, 16'hBBBB, 16'h8001, 16'h0013, 5'h00, 1'b0, 1'b0);
        applyStimulus("lsr",        12'h800, 16'hCCCC, 16'h8001, 16'h000F, 5'h00, 1'b0, 1'b0);
        applyStimulus("not",        12'h200, 16'hDDDD, 16'h0000, 16'h00FF, 5'h00, 1'b0, 1'b0);
        applyStimulus("mov_imm",    12'h400, 16'hEEEE, 16'h0000, 16'h0000, 5'h10, 1'b1, 1'b0);

        applyStimulus("pre_reset",  12'h001, 16'h4321, 16'h0003, 16'h0004, 5'h00, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("reset_async", 16'h0000, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    sel = 12'(1 << $urandom_range(0, 11));
                2:       sel = 12'($urandom);
                default: sel = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
            endcase
            applyStimulus("random", sel, 16'($urandom), 16'($urandom), 16'($urandom),
                          5'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
